systolic_job_sched: RTL and testbench

Scheduler that shares one combinational systolic array (ROW x COLUMN, single-bit output) between two requesters. It arbitrates round-robin, loads the winner's row/column operands into registers that drive the array, and waits a fixed settle window. It then samples the array output and returns it with the requester id over a valid/ready response channel. It sits between the job sources and the array instance; the array itself stays outside this block.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_rr_arb2.sv | 26 ++
 rtl/systolic_job_sched.sv | 111 +++++++++++
 tb/tb_systolic_job_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array slice: scheduler state encoding and
// default array operand widths (also used by the array top).
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } schedState_t;

  localparam int unsigned DEF_ROW    = 4;
  localparam int unsigned DEF_COLUMN = 11;

endpackage

// File: rtl/systolic_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances past the
// accepted requester when update is strobed.
module systolic_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] grant
);

  logic rrPtr;

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) grant = rrPtr ? 2'b10 : 2'b01;
    else if (req0)    grant = 2'b01;
    else if (req1)    grant = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rrPtr <= 1'b0;
    else if (update) rrPtr <= ~grant[1];
  end

endmodule

// File: rtl/systolic_job_sched.sv
// Shares one combinational systolic array between two requesters: round-robin
// grant, registered operand drive, fixed settle window, valid/ready result.
module systolic_job_sched
  import systolic_pkg::*;
#(
  parameter int unsigned ROW           = DEF_ROW,
  parameter int unsigned COLUMN        = DEF_COLUMN,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ROW-1:0]    req0_row,
  input  logic [COLUMN-1:0] req0_col,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ROW-1:0]    req1_row,
  input  logic [COLUMN-1:0] req1_col,
  output logic [ROW-1:0]    arr_row,
  output logic [COLUMN-1:0] arr_col,
  input  logic              arr_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_data,
  output logic              resp_id,
  output logic              busy,
  output logic [CNT_W-1:0]  jobs_done
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  schedState_t   state, stateNext;
  logic [1:0]    grant;
  logic          accept;
  logic          respFire;
  logic [CW-1:0] settleCnt;

  systolic_rr_arb2 uArb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .update (accept),
    .grant  (grant)
  );

  assign accept     = (state == IDLE) && (grant != 2'b00);
  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign respFire   = (state == RESP) && resp_valid && resp_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept)          stateNext = SETTLE;
      SETTLE:  if (settleCnt == '0) stateNext = RESP;
      RESP:    if (respFire)        stateNext = IDLE;
      default:                      stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_row    <= '0;
      arr_col    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= 1'b0;
      resp_id    <= 1'b0;
      jobs_done  <= '0;
      settleCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            arr_row   <= grant[1] ? req1_row : req0_row;
            arr_col   <= grant[1] ? req1_col : req0_col;
            resp_id   <= grant[1];
            settleCnt <= CW'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          // arr_out is only trusted on the last cycle of the window
          if (settleCnt == '0) begin
            resp_data  <= arr_out;
            resp_valid <= 1'b1;
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        RESP: begin
          if (respFire) begin
            resp_valid <= 1'b0;
            arr_row    <= '0;
            arr_col    <= '0;
            jobs_done  <= jobs_done + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_job_sched.sv
// Directed bench for systolic_job_sched; the bench plays the array and both
// requesters, with hand-computed expected values.
module tb_systolic_job_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_row, req1_row, arr_row;
  logic [10:0] req0_col, req1_col, arr_col;
  logic        arr_out, resp_valid, resp_ready, resp_data, resp_id, busy;
  logic [1:0]  jobs_done;

  int unsigned nCompared   = 0;
  int unsigned nMismatched = 0;

  always #5 clk = ~clk;

  systolic_job_sched #(
    .ROW           (4),
    .COLUMN        (11),
    .SETTLE_CYCLES (3),
    .CNT_W         (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_row   (req0_row),
    .req0_col   (req0_col),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_row   (req1_row),
    .req1_col   (req1_col),
    .arr_row    (arr_row),
    .arr_col    (arr_col),
    .arr_out    (arr_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_row = '0; req0_col = '0;
    req1_valid = 1'b0; req1_row = '0; req1_col = '0;
    arr_out    = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic waitResp(input string tag);
    int unsigned n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    checkVal(tag, resp_valid, 1);
  endtask

  task automatic runJob(input logic id, input string tag);
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    @(negedge clk);
    checkVal({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitResp({tag, "_resp"});
    checkVal({tag, "_id"}, resp_id, id);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    logic gSeq [4];
    logic rSeq [4];
    logic [1:0] jdSeq [4];
    int unsigned nG, nR;

    applyReset();
    @(negedge clk);
    checkVal("rst_arr_row", arr_row, 0);
    checkVal("rst_arr_col", arr_col, 0);
    checkVal("rst_resp_valid", resp_valid, 0);
    checkVal("rst_resp_data", resp_data, 0);
    checkVal("rst_jobs_done", jobs_done, 0);
    checkVal("rst_busy", busy, 0);
    tick();

    // Single job: array result is 1 only in cycle T+3
    req0_valid = 1'b1; req0_row = 4'hF; req0_col = 11'h7FF; arr_out = 1'b0;
    @(negedge clk);
    checkVal("sj_ready0", req0_ready, 1);
    checkVal("sj_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    checkVal("sj_arr_row", arr_row, 4'hF);
    checkVal("sj_arr_col", arr_col, 11'h7FF);
    checkVal("sj_busy", busy, 1);
    checkVal("sj_early_valid", resp_valid, 0);
    tick();
    tick();
    arr_out = 1'b1;
    @(negedge clk);
    checkVal("sj_t3_valid", resp_valid, 0);
    tick();
    arr_out = 1'b0;
    @(negedge clk);
    checkVal("sj_resp_valid", resp_valid, 1);
    checkVal("sj_resp_data", resp_data, 1);
    checkVal("sj_resp_id", resp_id, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    checkVal("sj_done_valid", resp_valid, 0);
    checkVal("sj_done_busy", busy, 0);
    checkVal("sj_done_arr_row", arr_row, 0);
    checkVal("sj_jobs_done", jobs_done, 1);
    tick();

    // Sampling window: array result is 1 everywhere except T+3
    req0_valid = 1'b1; req0_row = 4'h3; req0_col = 11'h055; arr_out = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    arr_out = 1'b0;
    tick();
    arr_out = 1'b1;
    @(negedge clk);
    checkVal("sw_resp_valid", resp_valid, 1);
    checkVal("sw_resp_data", resp_data, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkVal("sw_jobs_done", jobs_done, 2);

    // Contention from reset, consumer always ready
    applyReset();
    req0_valid = 1'b1; req0_row = 4'h1; req0_col = 11'h001;
    req1_valid = 1'b1; req1_row = 4'h2; req1_col = 11'h002;
    resp_ready = 1'b1;
    nG = 0; nR = 0;
    for (int cyc = 0; cyc < 60 && nR < 4; cyc++) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && nG < 4) begin
        gSeq[nG] = req1_ready;
        nG++;
      end
      if (resp_valid) begin
        rSeq[nR] = resp_id;
        nR++;
        tick();
        jdSeq[nR-1] = jobs_done;
      end else begin
        tick();
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    checkVal("ct_grants", nG, 4);
    checkVal("ct_resps", nR, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nG)) checkVal($sformatf("ct_grant%0d", i), gSeq[i], i % 2);
      if (i < int'(nR)) begin
        checkVal($sformatf("ct_resp_id%0d", i), rSeq[i], i % 2);
        checkVal($sformatf("ct_jobs_done%0d", i), jdSeq[i], (i + 1) % 4);
      end
    end

    // Back-pressure: req1 waits behind a stalled req0 response
    req0_valid = 1'b1; req0_row = 4'hA; req0_col = 11'h0AA; arr_out = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_row = 4'h5; req1_col = 11'h123;
    waitResp("bp_resp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal($sformatf("bp_valid%0d", i), resp_valid, 1);
      checkVal($sformatf("bp_data%0d", i), resp_data, 1);
      checkVal($sformatf("bp_id%0d", i), resp_id, 0);
      checkVal($sformatf("bp_ready1_%0d", i), req1_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkVal("bp_hs_ready1", req1_ready, 0);
    tick();
    resp_ready = 1'b0;
    arr_out = 1'b0;
    @(negedge clk);
    checkVal("bp_next_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    checkVal("bp_arr_row", arr_row, 4'h5);
    checkVal("bp_arr_col", arr_col, 11'h123);
    waitResp("bp_resp1");
    checkVal("bp_resp1_id", resp_id, 1);
    checkVal("bp_resp1_data", resp_data, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkVal("bp_jobs_done", jobs_done, 2);

    // Reset asserted mid-SETTLE discards the job
    req0_valid = 1'b1; req0_row = 4'h7; req0_col = 11'h3C3; arr_out = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("mr_arr_row", arr_row, 0);
    checkVal("mr_arr_col", arr_col, 0);
    checkVal("mr_resp_valid", resp_valid, 0);
    checkVal("mr_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    begin
      int unsigned seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      checkVal("mr_no_resp", seen, 0);
    end
    checkVal("mr_jobs_done", jobs_done, 0);
    checkVal("mr_idle", busy, 0);
    resp_ready = 1'b0;
    tick();

    // Counter wrap with a 2-bit counter
    applyReset();
    for (int i = 0; i < 5; i++) begin
      runJob(1'(i % 2), $sformatf("wr%0d", i));
      checkVal($sformatf("wr_jobs_done%0d", i), jobs_done, (i + 1) % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
